// File: rtl/boot_loader.sv
// Boot-time copy engine: moves a block of words from a one-cycle-latency source
// memory into instruction memory, one word every three clocks, with start/busy/done handshake.
module boot_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int SRC_ADDR_WIDTH = 12,
    parameter int LEN_WIDTH      = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SRC_ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0]     dst_base,
    input  logic [LEN_WIDTH-1:0]      length,
    output logic [SRC_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     src_q,
    output logic [ADDR_WIDTH-1:0]     dst_addr,
    output logic [DATA_WIDTH-1:0]     dst_data,
    output logic                      dst_we,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [SRC_ADDR_WIDTH-1:0] src_base_r, src_base_nx;
    logic [ADDR_WIDTH-1:0]     dst_base_r, dst_base_nx;
    logic [LEN_WIDTH-1:0]      len_r, len_nx;
    logic [LEN_WIDTH-1:0]      cnt, cnt_nx;
    logic [LEN_WIDTH-1:0]      cnt_inc;

    logic [SRC_ADDR_WIDTH-1:0] src_addr_nx;
    logic [ADDR_WIDTH-1:0]     dst_addr_nx;
    logic [DATA_WIDTH-1:0]     dst_data_nx;
    logic                      dst_we_nx;
    logic                      busy_nx;
    logic                      done_nx;

    // Base + offset with silent wrap to the address width of each memory.
    function automatic logic [SRC_ADDR_WIDTH-1:0] wrap_src(
        input logic [SRC_ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]      ofs
    );
        logic [SRC_ADDR_WIDTH+LEN_WIDTH-1:0] sum;
        sum = {{LEN_WIDTH{1'b0}}, base} + {{SRC_ADDR_WIDTH{1'b0}}, ofs};
        return sum[SRC_ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] wrap_dst(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]  ofs
    );
        logic [ADDR_WIDTH+LEN_WIDTH-1:0] sum;
        sum = {{LEN_WIDTH{1'b0}}, base} + {{ADDR_WIDTH{1'b0}}, ofs};
        return sum[ADDR_WIDTH-1:0];
    endfunction

    assign cnt_inc = cnt + LEN_WIDTH'(1);

    always_comb begin
        state_nx    = state;
        src_base_nx = src_base_r;
        dst_base_nx = dst_base_r;
        len_nx      = len_r;
        cnt_nx      = cnt;
        src_addr_nx = src_addr;
        dst_addr_nx = dst_addr;
        dst_data_nx = dst_data;
        dst_we_nx   = 1'b0;
        busy_nx     = busy;
        done_nx     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    src_base_nx = src_base;
                    dst_base_nx = dst_base;
                    len_nx      = length;
                    cnt_nx      = '0;
                    busy_nx     = 1'b1;
                    if (length != '0) begin
                        src_addr_nx = src_base;
                        state_nx    = S_REQ;
                    end else begin
                        // Empty copy: report completion without touching either memory.
                        done_nx  = 1'b1;
                        state_nx = S_DONE;
                    end
                end
            end
            S_REQ: begin
                state_nx = S_CAPT;
            end
            S_CAPT: begin
                dst_data_nx = src_q;
                dst_addr_nx = wrap_dst(dst_base_r, cnt);
                dst_we_nx   = 1'b1;
                state_nx    = S_WRITE;
            end
            S_WRITE: begin
                if (cnt_inc == len_r) begin
                    done_nx  = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx      = cnt_inc;
                    src_addr_nx = wrap_src(src_base_r, cnt_inc);
                    state_nx    = S_REQ;
                end
            end
            S_DONE: begin
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            src_base_r <= '0;
            dst_base_r <= '0;
            len_r      <= '0;
            cnt        <= '0;
            src_addr   <= '0;
            dst_addr   <= '0;
            dst_data   <= '0;
            dst_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            src_base_r <= src_base_nx;
            dst_base_r <= dst_base_nx;
            len_r      <= len_nx;
            cnt        <= cnt_nx;
            src_addr   <= src_addr_nx;
            dst_addr   <= dst_addr_nx;
            dst_data   <= dst_data_nx;
            dst_we     <= dst_we_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed and randomized copies checked cycle by cycle
// against a schedule computed from word index, base addresses and length.
module tb_boot_loader;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = 12;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b1;
    logic [SW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [LW-1:0] length = '0;
    logic [SW-1:0] src_addr;
    logic [DW-1:0] src_q;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_data;
    logic          dst_we, busy, done;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] salt = 32'h0;
    logic [31:0] last_addr = 0, last_data = 0, last_src = 0;
    logic [31:0] r;

    boot_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .src_addr(src_addr), .src_q(src_q),
        .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Source memory: word at address a reads as salt ^ a, one clock after the address.
    always @(posedge clk) src_q <= salt ^ {20'h0, src_addr};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs in cycle c after the accepting edge (c=1 is the cycle right after it).
    task automatic check_cycle(input int c, input int sb, input int db, input int n);
        bit we_exp;
        int k, ks;
        we_exp = (n > 0) && (c >= 3) && ((c - 3) % 3 == 0) && ((c - 3) / 3 < n);
        k = (c - 3) / 3;
        chk("dst_we", dst_we, we_exp);
        if (we_exp) begin
            last_addr = (db + k) % 1024;
            last_data = salt ^ ((sb + k) % 4096);
        end
        chk("dst_addr", dst_addr, last_addr);
        chk("dst_data", dst_data, last_data);
        chk("done", done, c == 3 * n + 1);
        chk("busy", busy, (c >= 1) && (c <= 3 * n + 1));
        if (n > 0) begin
            ks = (c - 1) / 3;
            if (ks > n - 1) ks = n - 1;
            chk("src_addr", src_addr, (sb + ks) % 4096);
        end else begin
            chk("src_addr_hold", src_addr, last_src);
        end
    endtask

    task automatic launch(input int sb, input int db, input int n);
        @(negedge clk);
        src_base = SW'(sb);
        dst_base = AW'(db);
        length   = LW'(n);
        start    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Follows a copy from cycle 1 to the first idle cycle; inputs are scrambled
    // after acceptance unless start is being held high.
    task automatic watch(input int sb, input int db, input int n, input bit keep);
        logic [31:0] t;
        for (int c = 1; c <= 3 * n + 1; c++) begin
            check_cycle(c, sb, db, n);
            @(negedge clk);
            if (!keep) begin
                start = 1'b0;
                t = $urandom;
                src_base = t[SW-1:0];
                dst_base = t[AW+SW-1:SW];
                length   = t[31:31-LW+1];
            end
            @(posedge clk);
            #1;
        end
        check_cycle(3 * n + 2, sb, db, n);
        if (n > 0) last_src = (sb + n - 1) % 4096;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"}, dst_we, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_src_addr"}, src_addr, '0);
        chk({tag, "_dst_addr"}, dst_addr, '0);
        chk({tag, "_dst_data"}, dst_data, '0);
    endtask

    initial begin
        int sb, db, n, sb2, db2, n2;

        // Reset held two cycles with start high.
        @(posedge clk); #1;
        check_reset_state("rst1");
        @(posedge clk); #1;
        check_reset_state("rst2");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check_reset_state("idle");

        // Directed copy with the reference source pattern.
        salt = 32'hA000_0000;
        launch(12'h010, 10'h000, 4);
        watch(12'h010, 10'h000, 4, 1'b0);

        // Zero-length copy.
        launch(12'h123, 10'h055, 0);
        watch(12'h123, 10'h055, 0, 1'b0);

        // Destination and source wrap.
        salt = 32'h5C00_0000;
        launch(12'hFFE, 10'h3FE, 3);
        watch(12'hFFE, 10'h3FE, 3, 1'b0);

        // start held high through a copy, then a second copy from the re-entered IDLE.
        salt = 32'h3300_0000;
        sb = 12'h200; db = 10'h100; n = 3;
        launch(sb, db, n);
        watch(sb, db, n, 1'b1);
        sb2 = 12'h7F0; db2 = 10'h020; n2 = 2;
        @(negedge clk);
        src_base = SW'(sb2);
        dst_base = AW'(db2);
        length   = LW'(n2);
        @(posedge clk); #1;
        watch(sb2, db2, n2, 1'b0);

        // Reset during the capture of word index 2 of a 5-word copy.
        salt = 32'h0F00_0000;
        sb = 12'h0A0; db = 10'h200; n = 5;
        launch(sb, db, n);
        for (int c = 1; c <= 7; c++) begin
            check_cycle(c, sb, db, n);
            @(negedge clk);
            start = 1'b0;
            @(posedge clk); #1;
        end
        check_cycle(8, sb, db, n);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state("midrst");
        last_addr = 0; last_data = 0; last_src = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("postrst_we", dst_we, 1'b0);
            chk("postrst_done", done, 1'b0);
            chk("postrst_busy", busy, 1'b0);
        end
        launch(sb, db, n);
        watch(sb, db, n, 1'b0);

        // Randomized copies.
        for (int t = 0; t < 8; t++) begin
            r = $urandom;
            salt = {r[31:12], 12'h000};
            r = $urandom;
            sb = int'(r[SW-1:0]);
            db = int'(r[AW+SW-1:SW]);
            n  = 1 + int'(r[31:29]);
            launch(sb, db, n);
            watch(sb, db, n, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
